// File: rtl/mem_rd_arb_pkg.sv
// Shared types and defaults for the memory read-port arbiter.
package mem_arb_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 128;
    localparam int DEF_QUANTUM = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GNT  = 1'b1
    } arb_state_t;

    // Bits needed to hold indices 0..value-1 (never less than one bit).
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/mem_rd_arb_if.sv
// Bundle of read-master and memory-side signals around the read-port arbiter.
interface mem_rd_arb_if #(
    parameter int NREQ = 4,
    parameter int AW   = 32,
    parameter int DW   = 128,
    parameter int IDXW = 2
);
    logic [NREQ-1:0]    rreq;
    logic [NREQ*AW-1:0] raddr;
    logic [NREQ-1:0]    grant;
    logic [DW-1:0]      rdata;
    logic               mem_rd;
    logic [AW-1:0]      mem_raddr;
    logic [DW-1:0]      mem_rdata;
    logic               busy;
    logic [IDXW-1:0]    owner;

    // The arbiter itself.
    modport slave (
        input  rreq, raddr, mem_rdata,
        output grant, rdata, mem_rd, mem_raddr, busy, owner
    );

    // Masters plus memory model surrounding the arbiter.
    modport master (
        output rreq, raddr, mem_rdata,
        input  grant, rdata, mem_rd, mem_raddr, busy, owner
    );
endinterface

// File: rtl/mem_rd_arb_rr_pick.sv
// Combinational rotating-priority encoder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] cand_idx [NREQ];
    logic [NREQ-1:0] rot_req;

    // rot_req[gi] is the request gi positions past ptr; ptr < NREQ so one subtraction wraps it.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [IDXW:0] sum;
        assign sum          = {1'b0, ptr} + (IDXW+1)'(gi);
        assign cand_idx[gi] = (sum >= (IDXW+1)'(NREQ)) ? IDXW'(sum - (IDXW+1)'(NREQ))
                                                       : sum[IDXW-1:0];
        assign rot_req[gi]  = req[cand_idx[gi]];
    end

    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_req[i]) idx = cand_idx[i];
        end
    end

endmodule

// File: rtl/mem_rd_arb.sv
// Round-robin arbiter for the shared memory read port; grant is held for a whole burst.
// Optional time-slice preemption is enabled by defining MEM_ARB_QUANTUM_EN.
module mem_rd_arb
    import mem_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int IDXW    = clog2(NREQ),
    parameter int QUANTUM = DEF_QUANTUM
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_rd_arb_if.slave  bus
);

    if (NREQ < 2 || NREQ > 16 || IDXW != clog2(NREQ) || QUANTUM < 1) begin : g_bad_params
        $error("mem_rd_arb: parameter out of range");
    end

    arb_state_t      state_reg;
    logic [NREQ-1:0] grant_reg;
    logic [IDXW-1:0] owner_reg;
    logic [IDXW-1:0] ptr_reg;
    logic [IDXW-1:0] ptr_next;
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;
    logic            owner_req;
    logic            release_now;
    logic [AW-1:0]   addr_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
        assign addr_arr[gi] = bus.raddr[gi*AW +: AW];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (bus.rreq),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign owner_req = bus.rreq[owner_reg];
    assign ptr_next  = (owner_reg == IDXW'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

`ifdef MEM_ARB_QUANTUM_EN
    localparam int QW = clog2(QUANTUM + 1);

    logic [QW-1:0] qcnt_reg;
    logic [QW-1:0] qcnt_next;
    logic          others_req;

    // grant_reg is one-hot on the owner while granted, so this masks out the owner only.
    assign others_req  = |(bus.rreq & ~grant_reg);
    assign qcnt_next   = (qcnt_reg == QW'(QUANTUM)) ? qcnt_reg : qcnt_reg + 1'b1;
    assign release_now = !owner_req || ((qcnt_next == QW'(QUANTUM)) && others_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            qcnt_reg <= '0;
        end else begin
            qcnt_reg <= qcnt_next;
        end
    end
`else
    assign release_now = !owner_req;
`endif

    // Every handoff goes through IDLE, giving one dead cycle between owners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg <= NREQ'(1) << pick_idx;
                        owner_reg <= pick_idx;
                        state_reg <= ST_GNT;
                    end
                end
                ST_GNT: begin
                    if (release_now) begin
                        grant_reg <= '0;
                        ptr_reg   <= ptr_next;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.busy      = (state_reg == ST_GNT);
    assign bus.owner     = owner_reg;
    assign bus.mem_rd    = bus.busy & owner_req;
    assign bus.mem_raddr = addr_arr[owner_reg];
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_mem_rd_arb.sv
// Scoreboard bench for mem_rd_arb: directed scenarios plus random bursty requests vs. a reference model.
module tb_mem_rd_arb;
    import mem_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int AW      = 32;
    localparam int DW      = 128;
    localparam int IDXW    = 2;
    localparam int QUANTUM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_rd_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDXW(IDXW)) bus ();

    mem_rd_arb #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .IDXW    (IDXW),
        .QUANTUM (QUANTUM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [NREQ-1:0] grant;
        logic            busy;
        logic [IDXW-1:0] owner;
        logic            mem_rd;
        logic [AW-1:0]   mem_raddr;
        logic [DW-1:0]   rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: who holds the port, where the rotation resumes, slice length used.
    bit              m_granted;
    int              m_owner;
    int              m_ptr;
    int              m_cnt;
    logic [NREQ-1:0] m_prev_req;

    // Observed grant sequence, packed one hex digit per new grant.
    logic [63:0]     order_code;
    int              order_cnt;
    int              mem_rd_seen;
    logic [NREQ-1:0] prev_grant;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model over one clock edge using the requests that were visible before it.
    task automatic model_edge();
        logic [NREQ-1:0] r;
        bit              rel;
        int              k;
        r = m_prev_req;
        if (!m_granted) begin
            for (int i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (!m_granted && r[k]) begin
                    m_owner   = k;
                    m_granted = 1'b1;
                    m_cnt     = 0;
                end
            end
        end else begin
            rel = !r[m_owner];
`ifdef MEM_ARB_QUANTUM_EN
            if (!rel) begin
                if (m_cnt < QUANTUM) m_cnt++;
                if (m_cnt == QUANTUM && (r & ~(NREQ'(1) << m_owner)) != '0) rel = 1'b1;
            end
`endif
            if (rel) begin
                m_granted = 1'b0;
                m_ptr     = (m_owner + 1) % NREQ;
            end
        end
    endtask

    task automatic model_reset();
        m_granted  = 1'b0;
        m_owner    = 0;
        m_ptr      = 0;
        m_cnt      = 0;
        m_prev_req = '0;
    endtask

    // One cycle of stimulus; the expected outputs for that cycle go to the scoreboard.
    task automatic step(input logic [NREQ-1:0] req);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        bus.rreq   = req;
        m_prev_req = req;
        for (int i = 0; i < NREQ; i++) bus.raddr[i*AW +: AW] = $urandom;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        e.grant     = m_granted ? (NREQ'(1) << m_owner) : '0;
        e.busy      = m_granted;
        e.owner     = IDXW'(m_owner);
        e.mem_rd    = m_granted && req[m_owner];
        e.mem_raddr = bus.raddr[m_owner*AW +: AW];
        e.rdata     = bus.mem_rdata;
        exp_q.push_back(e);
    endtask

    // Assert reset away from the clock edge so a purely synchronous reset would be noticed.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_grant", DW'(bus.grant), '0);
        check("rst_busy", DW'(bus.busy), '0);
        check("rst_mem_rd", DW'(bus.mem_rd), '0);
        @(posedge clk);
        #1;
        check("rst_owner", DW'(bus.owner), '0);
        model_reset();
        bus.rreq   = '0;
        rst_n      = 1'b1;
        order_code = '0;
        order_cnt  = 0;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
        check("queue_drained", DW'(exp_q.size()), '0);
    endtask

    // Monitor: compare DUT outputs against the scoreboard once per cycle, away from the edge.
    initial begin
        prev_grant  = '0;
        mem_rd_seen = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.mem_rd) mem_rd_seen++;
                if (bus.grant != '0 && prev_grant == '0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (bus.grant[i]) begin
                            order_code = (order_code << 4) | 64'(i);
                            order_cnt++;
                            $display("grant master %0d at %0t", i, $time);
                        end
                    end
                end
            end
            prev_grant = bus.grant;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("grant", DW'(bus.grant), DW'(mon_e.grant));
                check("busy", DW'(bus.busy), DW'(mon_e.busy));
                check("owner", DW'(bus.owner), DW'(mon_e.owner));
                check("mem_rd", DW'(bus.mem_rd), DW'(mon_e.mem_rd));
                check("mem_raddr", DW'(bus.mem_raddr), DW'(mon_e.mem_raddr));
                check("rdata", bus.rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rq;
        int              hold;
        int              rd_base;

        bus.rreq      = '0;
        bus.raddr     = '0;
        bus.mem_rdata = '0;
        model_reset();
        order_code = '0;
        order_cnt  = 0;
        #3;
        check("init_grant", DW'(bus.grant), '0);
        check("init_busy", DW'(bus.busy), '0);
        check("init_owner", DW'(bus.owner), '0);
        check("init_mem_rd", DW'(bus.mem_rd), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Lone master, 8-cycle request: one-cycle grant latency, 7 reads.
        rd_base = mem_rd_seen;
        for (int c = 0; c < 8; c++) step(4'b0001);
        for (int c = 0; c < 4; c++) step(4'b0000);
        drain();
        check("single_mem_rd_count", DW'(mem_rd_seen - rd_base), DW'(7));
        check("single_order", DW'(order_code), DW'(64'h0));
        check("single_order_cnt", DW'(order_cnt), DW'(1));

        // All four request together; each drops after three grant cycles.
        apply_reset();
        rq   = 4'b1111;
        hold = 0;
        for (int c = 0; c < 30; c++) begin
            step(rq);
            if (m_granted) begin
                hold++;
                if (hold == 3) begin
                    rq[m_owner] = 1'b0;
                    hold        = 0;
                end
            end
        end
        for (int c = 0; c < 3; c++) step(4'b0000);
        drain();
        check("all4_order", DW'(order_code), DW'(64'h0123));
        check("all4_order_cnt", DW'(order_cnt), DW'(4));

        // Master 2 bursting, master 0 waiting: 0 is next after 2 releases.
        apply_reset();
        for (int c = 0; c < 4; c++) step(4'b0100);
        for (int c = 0; c < 3; c++) step(4'b0101);
        for (int c = 0; c < 4; c++) step(4'b0001);
        for (int c = 0; c < 3; c++) step(4'b0000);
        drain();
        check("m2_then_m0_order", DW'(order_code), DW'(64'h20));
        check("m2_then_m0_cnt", DW'(order_cnt), DW'(2));

        // Same, but master 3 also waiting: it wins over 0, then 0 follows.
        apply_reset();
        for (int c = 0; c < 4; c++) step(4'b0100);
        for (int c = 0; c < 3; c++) step(4'b1101);
        for (int c = 0; c < 4; c++) step(4'b1001);
        for (int c = 0; c < 4; c++) step(4'b0001);
        for (int c = 0; c < 3; c++) step(4'b0000);
        drain();
        check("m2_m3_m0_order", DW'(order_code), DW'(64'h230));
        check("m2_m3_m0_cnt", DW'(order_cnt), DW'(3));

`ifdef MEM_ARB_QUANTUM_EN
        // Two competing masters alternate in QUANTUM-cycle slices.
        apply_reset();
        for (int c = 0; c < 22; c++) step(4'b0011);
        for (int c = 0; c < 3; c++) step(4'b0000);
        drain();
        check("quantum_order", DW'(order_code), DW'(64'h01010));
        check("quantum_order_cnt", DW'(order_cnt), DW'(5));

        // A lone master keeps the grant past the quantum.
        apply_reset();
        for (int c = 0; c < 21; c++) step(4'b0001);
        for (int c = 0; c < 3; c++) step(4'b0000);
        drain();
        check("quantum_alone_cnt", DW'(order_cnt), DW'(1));
`endif

        // Reset while master 1 holds the grant, then master 1 is regranted from ptr=0.
        apply_reset();
        for (int c = 0; c < 4; c++) step(4'b0010);
        drain();
        check("pre_reset_grant", DW'(bus.grant), DW'(4'b0010));
        apply_reset();
        for (int c = 0; c < 4; c++) step(4'b0010);
        for (int c = 0; c < 2; c++) step(4'b0000);
        drain();
        check("post_reset_order", DW'(order_code), DW'(64'h1));
        check("post_reset_cnt", DW'(order_cnt), DW'(1));

        // Random bursty traffic against the model.
        apply_reset();
        rq = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i]) begin
                    if ($urandom_range(5) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    rq[i] = 1'b1;
                end
            end
            step(rq);
        end
        for (int c = 0; c < 3; c++) step(4'b0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
